i2c_target_phy: RTL and testbench
=================================

// Module: i2c_target_phy
// PURPOSE
//  Bit-level I2C target (slave) PHY: the responding end of the bus driven by the controller PHY.
//  - Synchronises and filters SCL/SDA, detects START/STOP, and delivers received bits.
//  - Drives SDA during SCL-low phases for ACK and read data; optionally stretches SCL.
//  - Sits below the byte/address target FSM, which consumes bit events and supplies tx bits.
// PARAMETERS
//  FILTER_LEN   4   consecutive identical samples before a filtered line changes (>=1)
//  HOLD_CYCLES  8   clk cycles after filtered SCL fall before SDA may change (>=1, tHD;DAT)
// PORTS
//  clk          in   1   clock
//  rst          in   1   synchronous reset, active-high
//  scl_i        in   1   raw SCL pad input (asynchronous)
//  sda_i        in   1   raw SDA pad input (asynchronous)
//  scl_o        out  1   SCL output value (0 = pull low)
//  scl_t        out  1   SCL tristate (1 = released); always equals scl_o
//  sda_o        out  1   SDA output value
//  sda_t        out  1   SDA tristate (1 = released); always equals sda_o
//  tx_en        in   1   drive SDA this bit (0 = release, i.e. NACK/read-1/listen)
//  tx_bit       in   1   value to drive when tx_en=1 (only 0 pulls low)
//  stretch_req  in   1   hold SCL low while asserted during a low phase
//  evt_start    out  1   1-cycle pulse: START or repeated START detected
//  evt_stop     out  1   1-cycle pulse: STOP detected
//  rx_valid     out  1   1-cycle pulse on filtered SCL fall: completed bit
//  rx_bit       out  1   SDA sampled at filtered SCL rise; valid with rx_valid
//  bus_busy     out  1   1 between START and STOP
//  phy_state    out  2   current state, for debug
// BEHAVIOUR
//  Reset values:
//  - scl_o/scl_t/sda_o/sda_t = 1; all pulses 0; rx_bit = 0; bus_busy = 0; state IDLE; hold counter 0.
//  Input path:
//  - 2-FF synchroniser per line, then filter.
//  - Filtered output updates only after FILTER_LEN equal synchronised samples.
//  - Total input latency 2+FILTER_LEN cycles. Edges are computed on filtered values vs previous cycle.
//  START / STOP detection:
//  - START = filtered SDA 1->0 while filtered SCL is 1 in both current and previous cycle.
//  - STOP = SDA 0->1 under the same SCL condition.
//  - An SCL edge in the same cycle as an SDA edge is an SCL edge only.
//  States:
//  - IDLE  : ignore bits. START -> SHOLD.
//  - SHOLD : after START, wait for SCL fall -> LOW. No rx_valid for this fall.
//  - LOW   : SCL low.
//      - Entry starts hold counter = HOLD_CYCLES.
//      - At 0: if stretch_req=1, drive scl_o=0 and wait; else latch sda_o = ~(tx_en & ~tx_bit).
//      - scl_o returns to 1 in the cycle after stretch_req falls, with SDA latched that same cycle.
//      - SCL rise -> sample rx_bit -> HIGH.
//      - SCL rise before counter expiry: latch SDA immediately, no error.
//  - HIGH  : SCL fall -> rx_valid=1 -> LOW. START -> SHOLD. STOP -> IDLE. Pending bit discarded (no rx_valid).
//  Global rules:
//  - START in any state (incl. LOW via glitch-free repeated start) -> evt_start, bus_busy=1, SHOLD.
//  - STOP in any state -> evt_stop, bus_busy=0, IDLE.
//  - On START/STOP, sda_o and scl_o release (1) in the same cycle.
//  - SDA changes only in LOW after hold expiry or on release events; never while SCL is high.
//  - Upper layer has HOLD_CYCLES-1 cycles after rx_valid to present tx_en/tx_bit.
//  - Reset mid-transfer: lines released immediately; remaining bits ignored until next START.
// STRUCTURE
//  - Shared include i2c_defs.vh: TPHY_IDLE=2'd0, TPHY_SHOLD=2'd1, TPHY_LOW=2'd2, TPHY_HIGH=2'd3.
//  - Sub-module i2c_input_filter (sync + FILTER_LEN filter), instantiated for SCL and SDA.
//  - Hold counter width is $clog2(HOLD_CYCLES+1).
// TESTING
//  1. Controller sends START, 0xA6, releases for ACK. Expect:
//     - evt_start once; 8 rx_valid with rx_bit 1,0,1,0,0,1,1,0; bus_busy=1.
//  2. ACK: tx_en=1, tx_bit=0 after 8th rx_valid -> sda_o=0 exactly HOLD_CYCLES after SCL fall.
//     SDA released HOLD_CYCLES after the 9th fall.
//  3. Read byte 0x5A via tx_en/tx_bit -> SDA pattern 0,1,0,1,1,0,1,0 stable during every SCL-high.
//  4. stretch_req held 50 cycles in LOW -> scl_o=0 for those cycles; scl_o=1 the cycle after release.
//  5. Repeated START mid-byte after 3 bits -> evt_start, no 4th rx_valid; STOP -> evt_stop, bus_busy=0.
//  6. Glitches and reset:
//     - Glitch of FILTER_LEN-1 cycles on SCL -> no rx_valid.
//     - rst asserted while driving SDA low -> sda_o=1 the next cycle, state IDLE.

Source files
------------

// File: rtl/i2c_target_phy_pkg.sv
// Shared definitions for the I2C target PHY: debug state encoding and the
// SDA drive rule used when a bit is latched onto the bus.
package i2c_target_phy_pkg;

    typedef enum logic [1:0] {
        TPHY_IDLE  = 2'd0,
        TPHY_SHOLD = 2'd1,
        TPHY_LOW   = 2'd2,
        TPHY_HIGH  = 2'd3
    } tphy_state_e;

    // Open-drain drive: only an enabled 0 pulls SDA low, everything else releases.
    function automatic logic sda_drive(input logic tx_en, input logic tx_bit);
        return ~(tx_en & ~tx_bit);
    endfunction

endpackage

// File: rtl/i2c_input_filter.sv
// Two-flop synchroniser followed by a run-length filter: the filtered level
// only follows the synchronised input after FILTER_LEN consecutive equal samples.
module i2c_input_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic filt
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    // Metastability guard; idle bus level is high
    always_ff @(posedge clk) begin
        if (rst) sync <= 2'b11;
        else     sync <= {sync[0], raw};
    end

    // Count samples that disagree with the filtered level; any agreement restarts the run
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            filt <= 1'b1;
        end else if (sync[1] == filt) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            filt <= sync[1];
            cnt  <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/i2c_target_phy.sv
// Bit-level I2C target PHY: filters the bus, detects START/STOP, reports
// received bits on SCL fall, drives SDA after the hold time and stretches SCL.
module i2c_target_phy
    import i2c_target_phy_pkg::*;
#(
    parameter int FILTER_LEN  = 4,
    parameter int HOLD_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       scl_o,
    output logic       scl_t,
    output logic       sda_o,
    output logic       sda_t,
    input  logic       tx_en,
    input  logic       tx_bit,
    input  logic       stretch_req,
    output logic       evt_start,
    output logic       evt_stop,
    output logic       rx_valid,
    output logic       rx_bit,
    output logic       bus_busy,
    output logic [1:0] phy_state
);

    localparam int HCW = $clog2(HOLD_CYCLES + 1);
    localparam logic [HCW-1:0] HOLD_INIT = HCW'(HOLD_CYCLES);

    logic scl_f, sda_f, scl_prev, sda_prev;
    logic scl_rise, scl_fall, start_det, stop_det, drive_val;

    tphy_state_e    state, state_n;
    logic [HCW-1:0] hold_cnt, hold_cnt_n;
    logic           latched, latched_n;
    logic           scl_n, sda_n, rx_bit_n, busy_n, start_n, stop_n, rxv_n;

    i2c_input_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
        .clk  (clk),
        .rst  (rst),
        .raw  (scl_i),
        .filt (scl_f)
    );

    i2c_input_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
        .clk  (clk),
        .rst  (rst),
        .raw  (sda_i),
        .filt (sda_f)
    );

    // Previous filtered levels for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_prev <= scl_f;
            sda_prev <= sda_f;
        end
    end

    // START/STOP require SCL high on both cycles, so a simultaneous SCL edge wins
    assign scl_rise  = scl_f & ~scl_prev;
    assign scl_fall  = ~scl_f & scl_prev;
    assign start_det = scl_f & scl_prev & sda_prev & ~sda_f;
    assign stop_det  = scl_f & scl_prev & ~sda_prev & sda_f;
    assign drive_val = sda_drive(tx_en, tx_bit);

    assign scl_t     = scl_o;
    assign sda_t     = sda_o;
    assign phy_state = state;

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= TPHY_IDLE;
            hold_cnt  <= '0;
            latched   <= 1'b0;
            scl_o     <= 1'b1;
            sda_o     <= 1'b1;
            rx_bit    <= 1'b0;
            bus_busy  <= 1'b0;
            evt_start <= 1'b0;
            evt_stop  <= 1'b0;
            rx_valid  <= 1'b0;
        end else begin
            state     <= state_n;
            hold_cnt  <= hold_cnt_n;
            latched   <= latched_n;
            scl_o     <= scl_n;
            sda_o     <= sda_n;
            rx_bit    <= rx_bit_n;
            bus_busy  <= busy_n;
            evt_start <= start_n;
            evt_stop  <= stop_n;
            rx_valid  <= rxv_n;
        end
    end

    // Next-state logic: bus conditions override the per-state bit handling
    always_comb begin
        state_n    = state;
        hold_cnt_n = hold_cnt;
        latched_n  = latched;
        scl_n      = scl_o;
        sda_n      = sda_o;
        rx_bit_n   = rx_bit;
        busy_n     = bus_busy;
        start_n    = 1'b0;
        stop_n     = 1'b0;
        rxv_n      = 1'b0;

        if (start_det) begin
            start_n    = 1'b1;
            busy_n     = 1'b1;
            state_n    = TPHY_SHOLD;
            scl_n      = 1'b1;
            sda_n      = 1'b1;
            hold_cnt_n = '0;
            latched_n  = 1'b0;
        end else if (stop_det) begin
            stop_n     = 1'b1;
            busy_n     = 1'b0;
            state_n    = TPHY_IDLE;
            scl_n      = 1'b1;
            sda_n      = 1'b1;
            hold_cnt_n = '0;
            latched_n  = 1'b0;
        end else begin
            case (state)
                TPHY_SHOLD: begin
                    if (scl_fall) begin
                        state_n    = TPHY_LOW;
                        hold_cnt_n = HOLD_INIT;
                        latched_n  = 1'b0;
                    end
                end
                TPHY_LOW: begin
                    if (scl_rise) begin
                        state_n    = TPHY_HIGH;
                        rx_bit_n   = sda_f;
                        scl_n      = 1'b1;
                        hold_cnt_n = '0;
                        latched_n  = 1'b1;
                        if (!latched) sda_n = drive_val;
                    end else begin
                        if (hold_cnt != '0) hold_cnt_n = hold_cnt - HCW'(1);
                        // Hold time ends on the cycle the counter reaches zero
                        if (!latched && hold_cnt <= HCW'(1)) begin
                            if (stretch_req) begin
                                scl_n = 1'b0;
                            end else begin
                                scl_n     = 1'b1;
                                sda_n     = drive_val;
                                latched_n = 1'b1;
                            end
                        end
                    end
                end
                TPHY_HIGH: begin
                    if (scl_fall) begin
                        rxv_n      = 1'b1;
                        state_n    = TPHY_LOW;
                        hold_cnt_n = HOLD_INIT;
                        latched_n  = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_target_phy.sv
// Scoreboard bench for i2c_target_phy: a controller model drives the wired-AND
// bus, expected events are queued as stimulus is issued and a monitor checks them.
module tb_i2c_target_phy;

    localparam int FILTER_LEN  = 4;
    localparam int HOLD_CYCLES = 8;
    localparam int K_START = 0, K_STOP = 1, K_BIT = 2;

    logic clk = 1'b0;
    logic rst;
    logic ctrl_scl, ctrl_sda;
    logic scl_i, sda_i, scl_o, scl_t, sda_o, sda_t;
    logic tx_en, tx_bit, stretch_req;
    logic evt_start, evt_stop, rx_valid, rx_bit, bus_busy;
    logic [1:0] phy_state;

    typedef struct packed {
        logic [1:0] kind;
        logic       bit_v;
        logic       busy;
    } ev_t;

    ev_t exp_q[$];
    int vectors = 0;
    int miscompares = 0;

    assign scl_i = ctrl_scl & scl_o;
    assign sda_i = ctrl_sda & sda_o;

    always #5 clk = ~clk;

    i2c_target_phy #(.FILTER_LEN(FILTER_LEN), .HOLD_CYCLES(HOLD_CYCLES)) dut (
        .clk         (clk),
        .rst         (rst),
        .scl_i       (scl_i),
        .sda_i       (sda_i),
        .scl_o       (scl_o),
        .scl_t       (scl_t),
        .sda_o       (sda_o),
        .sda_t       (sda_t),
        .tx_en       (tx_en),
        .tx_bit      (tx_bit),
        .stretch_req (stretch_req),
        .evt_start   (evt_start),
        .evt_stop    (evt_stop),
        .rx_valid    (rx_valid),
        .rx_bit      (rx_bit),
        .bus_busy    (bus_busy),
        .phy_state   (phy_state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic void push(input int kind, input logic bit_v, input logic busy);
        ev_t e;
        e.kind  = 2'(kind);
        e.bit_v = bit_v;
        e.busy  = busy;
        exp_q.push_back(e);
    endfunction

    task automatic pop_check(input int kind, input logic bit_v);
        ev_t e;
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_event: got kind %0d, expected no event (t=%0t)", kind, $time);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", 32'(kind), 32'(e.kind));
            if (kind == K_BIT) check("rx_bit", 32'(bit_v), 32'(e.bit_v));
            check("bus_busy_at_event", 32'(bus_busy), 32'(e.busy));
        end
    endtask

    // Monitor: every DUT event is matched against the head of the expectation queue
    always @(negedge clk) begin
        if (!rst) begin
            if (evt_start) pop_check(K_START, 1'b0);
            if (evt_stop)  pop_check(K_STOP, 1'b0);
            if (rx_valid)  pop_check(K_BIT, rx_bit);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_scl_high();
        int n = 0;
        while (scl_i !== 1'b1 && n < 300) begin
            cyc(1);
            n++;
        end
        check("scl_high_timeout", 32'(scl_i), 32'd1);
    endtask

    // One SCL cycle starting in the low phase; tx for the next bit is applied after rx_valid
    task automatic clock_bit(input logic cb, input logic exp_rx, input logic nen,
                             input logic nbit, input int stretch, input bit glitch);
        int bad;
        int n;
        if (stretch > 0) begin
            stretch_req = 1'b1;
            n = 0;
            while (scl_o !== 1'b0 && n < 40) begin
                cyc(1);
                n++;
            end
            check("stretch_assert", 32'(scl_o), 32'd0);
            bad = 0;
            for (int i = 0; i < stretch; i++) begin
                cyc(1);
                if (scl_o !== 1'b0) bad++;
            end
            check("stretch_held_bad_cycles", 32'(bad), 32'd0);
            stretch_req = 1'b0;
            cyc(1);
            check("stretch_release_scl", 32'(scl_o), 32'd1);
            check("stretch_release_sda", 32'(sda_o), 32'(exp_rx));
        end
        cyc(6);
        ctrl_sda = cb;
        cyc(18);
        ctrl_scl = 1'b1;
        wait_scl_high();
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (glitch && i == 8)  ctrl_scl = 1'b0;
            if (glitch && i == 11) ctrl_scl = 1'b1;
            if (sda_i !== exp_rx) bad++;
            cyc(1);
        end
        check("sda_stable_while_scl_high", 32'(bad), 32'd0);
        push(K_BIT, exp_rx, 1'b1);
        ctrl_scl = 1'b0;
        n = 0;
        while (rx_valid !== 1'b1 && n < 30) begin
            cyc(1);
            n++;
        end
        check("rx_valid_timeout", 32'(rx_valid), 32'd1);
        tx_en  = nen;
        tx_bit = nbit;
    endtask

    task automatic send_start();
        if (ctrl_scl == 1'b0) begin
            cyc(6);
            ctrl_sda = 1'b1;
            cyc(10);
            ctrl_scl = 1'b1;
            wait_scl_high();
        end
        cyc(20);
        push(K_START, 1'b0, 1'b1);
        ctrl_sda = 1'b0;
        cyc(20);
        ctrl_scl = 1'b0;
    endtask

    task automatic send_stop();
        cyc(6);
        ctrl_sda = 1'b0;
        cyc(10);
        ctrl_scl = 1'b1;
        wait_scl_high();
        cyc(20);
        push(K_STOP, 1'b0, 1'b0);
        ctrl_sda = 1'b1;
        cyc(20);
    endtask

    task automatic write_byte(input logic [7:0] b, input bit ack_next, input int glitch_bit);
        for (int i = 7; i >= 0; i--)
            clock_bit(b[i], b[i], (i == 0) && ack_next, 1'b0, 0, i == glitch_bit);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd;
        logic [8:0] rd_ext;
        int n;
        rd = 8'h5A;
        rd_ext = {rd, 1'b0};
        rst = 1'b1;
        ctrl_scl = 1'b1;
        ctrl_sda = 1'b1;
        tx_en = 1'b0;
        tx_bit = 1'b0;
        stretch_req = 1'b0;
        cyc(3);
        check("rst_scl_o", 32'(scl_o), 32'd1);
        check("rst_scl_t", 32'(scl_t), 32'd1);
        check("rst_sda_o", 32'(sda_o), 32'd1);
        check("rst_sda_t", 32'(sda_t), 32'd1);
        check("rst_pulses", {29'd0, evt_start, evt_stop, rx_valid}, 32'd0);
        check("rst_rx_bit", 32'(rx_bit), 32'd0);
        check("rst_bus_busy", 32'(bus_busy), 32'd0);
        check("rst_state", 32'(phy_state), 32'd0);
        rst = 1'b0;
        cyc(20);

        // START, write 0xA6 with a short SCL glitch inside one high phase
        send_start();
        write_byte(8'hA6, 1'b1, 5);
        check("bus_busy_in_transfer", 32'(bus_busy), 32'd1);

        // ACK appears exactly HOLD_CYCLES after the 8th rx_valid
        cyc(HOLD_CYCLES - 1);
        check("ack_not_before_hold", 32'(sda_o), 32'd1);
        cyc(1);
        check("ack_at_hold", 32'(sda_o), 32'd0);
        clock_bit(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        cyc(HOLD_CYCLES - 1);
        check("ack_held_until_hold", 32'(sda_o), 32'd0);
        cyc(1);
        check("ack_release_at_hold", 32'(sda_o), 32'd1);

        // Three bits then a repeated START: the pending 4th bit is dropped
        clock_bit(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        clock_bit(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        clock_bit(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        send_start();
        check("state_after_rstart", 32'(phy_state), 32'd1);

        // Read address, ACK, then read 0x5A with a 50-cycle stretch on the first bit
        write_byte(8'hA7, 1'b1, -1);
        clock_bit(1'b1, 1'b0, 1'b1, rd[7], 0, 1'b0);
        for (int i = 7; i >= 0; i--)
            clock_bit(1'b1, rd[i], i > 0, rd_ext[i], (i == 7) ? 50 : 0, 1'b0);
        clock_bit(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        send_stop();
        check("bus_busy_after_stop", 32'(bus_busy), 32'd0);
        check("state_after_stop", 32'(phy_state), 32'd0);

        // Reset while the target is pulling SDA low for an ACK
        send_start();
        write_byte(8'h10, 1'b1, -1);
        n = 0;
        while (sda_o !== 1'b0 && n < 20) begin
            cyc(1);
            n++;
        end
        check("ack_before_reset", 32'(sda_o), 32'd0);
        rst = 1'b1;
        cyc(1);
        check("reset_sda_release", 32'(sda_o), 32'd1);
        check("reset_state_idle", 32'(phy_state), 32'd0);
        check("reset_bus_busy", 32'(bus_busy), 32'd0);
        check("reset_scl_release", 32'(scl_o), 32'd1);
        rst = 1'b0;
        tx_en = 1'b0;
        tx_bit = 1'b0;
        cyc(6);
        ctrl_sda = 1'b1;
        cyc(10);
        ctrl_scl = 1'b1;
        cyc(40);
        send_start();
        send_stop();

        cyc(50);
        check("expected_events_outstanding", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
